// File: rtl/wb_payload_arbiter.sv
// Two-master Wishbone arbiter for the fwpayload target port: round-robin grant,
// cycle-long bus hold and a stb-without-ack watchdog that flushes stuck owners.
module wb_payload_arbiter #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,

  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [DAT_WIDTH/8-1:0] m0_sel_i,
  input  logic [ADR_WIDTH-1:0]   m0_adr_i,
  input  logic [DAT_WIDTH-1:0]   m0_dat_i,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  output logic [DAT_WIDTH-1:0]   m0_dat_o,

  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [DAT_WIDTH/8-1:0] m1_sel_i,
  input  logic [ADR_WIDTH-1:0]   m1_adr_i,
  input  logic [DAT_WIDTH-1:0]   m1_dat_i,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  output logic [DAT_WIDTH-1:0]   m1_dat_o,

  output logic                   t_cyc_o,
  output logic                   t_stb_o,
  output logic                   t_we_o,
  output logic [DAT_WIDTH/8-1:0] t_sel_o,
  output logic [ADR_WIDTH-1:0]   t_adr_o,
  output logic [DAT_WIDTH-1:0]   t_dat_o,
  input  logic                   t_ack_i,
  input  logic [DAT_WIDTH-1:0]   t_dat_i,

  output logic [1:0]             grant_o,
  output logic                   timeout_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0] TO_CMP = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT0  = 2'd1,
    S_GNT1  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             own0, own1;
  logic             req0, req1;
  logic [CNT_W:0]   cnt_inc;
  logic             fire;
  logic             owner_cyc;

  assign own0 = (state_q == S_GNT0);
  assign own1 = (state_q == S_GNT1);
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Target-side mux: only the owner reaches the target; idle and flush drive zeros.
  always_comb begin
    t_cyc_o = 1'b0;
    t_stb_o = 1'b0;
    t_we_o  = 1'b0;
    t_sel_o = '0;
    t_adr_o = '0;
    t_dat_o = '0;
    if (own0) begin
      t_cyc_o = m0_cyc_i;
      t_stb_o = m0_stb_i;
      t_we_o  = m0_we_i;
      t_sel_o = m0_sel_i;
      t_adr_o = m0_adr_i;
      t_dat_o = m0_dat_i;
    end else if (own1) begin
      t_cyc_o = m1_cyc_i;
      t_stb_o = m1_stb_i;
      t_we_o  = m1_we_i;
      t_sel_o = m1_sel_i;
      t_adr_o = m1_adr_i;
      t_dat_o = m1_dat_i;
    end
  end

  // The watchdog fires in the cycle the count would reach TIMEOUT; a same-cycle ack wins.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign fire    = (TIMEOUT != 0) && (own0 || own1) && t_stb_o && !t_ack_i
                   && (cnt_inc == TO_CMP);

  always_comb begin
    cnt_d = '0;
    if ((TIMEOUT != 0) && (own0 || own1) && t_stb_o && !t_ack_i) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  // Master-side return path: ack and read data go only to the owner, combinationally.
  always_comb begin
    m0_ack_o  = own0 & t_ack_i;
    m1_ack_o  = own1 & t_ack_i;
    m0_err_o  = own0 & fire;
    m1_err_o  = own1 & fire;
    m0_dat_o  = own0 ? t_dat_i : '0;
    m1_dat_o  = own1 ? t_dat_i : '0;
    grant_o   = {own1, own0};
    timeout_o = fire;
  end

  // In FLUSH the offending master is always the most recently granted one.
  assign owner_cyc = last_q ? m1_cyc_i : m0_cyc_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? S_GNT0 : S_GNT1;
          last_d  = ~last_q;
        end else if (req0) begin
          state_d = S_GNT0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = S_GNT1;
          last_d  = 1'b1;
        end
      end
      S_GNT0: begin
        if (fire)           state_d = S_FLUSH;
        else if (!m0_cyc_i) state_d = S_IDLE;
      end
      S_GNT1: begin
        if (fire)           state_d = S_FLUSH;
        else if (!m1_cyc_i) state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (!owner_cyc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_payload_arbiter.sv
// Bench for wb_payload_arbiter: directed scenarios plus a randomized run against
// a cycle-level reference model of the arbitration and watchdog rules.
module tb_wb_payload_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i;
  logic [DW-1:0] m0_dat_i, m1_dat_i;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          t_cyc_o, t_stb_o, t_we_o, t_ack_i;
  logic [SW-1:0] t_sel_o;
  logic [AW-1:0] t_adr_o;
  logic [DW-1:0] t_dat_o, t_dat_i;
  logic [1:0]    grant_o;
  logic          timeout_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_payload_arbiter #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .t_cyc_o(t_cyc_o), .t_stb_o(t_stb_o), .t_we_o(t_we_o), .t_sel_o(t_sel_o),
    .t_adr_o(t_adr_o), .t_dat_o(t_dat_o), .t_ack_i(t_ack_i), .t_dat_i(t_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0; m0_adr_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0; m1_adr_i = '0; m1_dat_i = '0;
    t_ack_i = 0; t_dat_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if ({grant_o, timeout_o, t_cyc_o, t_stb_o, t_we_o, t_sel_o} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b exp=0", {grant_o, timeout_o, t_cyc_o, t_stb_o, t_we_o, t_sel_o});
    end
    vectors++;
    if ({t_adr_o, t_dat_o, m0_dat_o, m1_dat_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got adr=%h dat=%h m0d=%h m1d=%h acks=%b", t_adr_o, t_dat_o,
               m0_dat_o, m1_dat_o, {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    idle_inputs();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
    m0_adr_i = 32'h100; m0_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    vectors++;
    if ({grant_o, t_cyc_o, t_stb_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL wr_latency got=%b exp=0000", {grant_o, t_cyc_o, t_stb_o});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({grant_o, t_cyc_o, t_stb_o, t_we_o, t_sel_o, m0_ack_o} !== {2'b01, 3'b111, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL wr_grant got=%b exp=%b", {grant_o, t_cyc_o, t_stb_o, t_we_o, t_sel_o, m0_ack_o},
               {2'b01, 3'b111, 4'hF, 1'b0});
    end
    vectors++;
    if ({t_adr_o, t_dat_o} !== {32'h100, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL wr_payload got adr=%h dat=%h exp adr=100 dat=deadbeef", t_adr_o, t_dat_o);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (m0_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_wait got ack=%b exp=0", m0_ack_o);
    end
    tick();
    t_ack_i = 1;
    @(negedge clk);
    vectors++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, grant_o} !== 5'b10001) begin
      miscompares++;
      $display("FAIL wr_ack got=%b exp=10001", {m0_ack_o, m0_err_o, m1_ack_o, grant_o});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if ({grant_o, t_cyc_o} !== 3'b010) begin
      miscompares++;
      $display("FAIL wr_release got=%b exp=010", {grant_o, t_cyc_o});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({grant_o, t_cyc_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL wr_idle got=%b exp=000", {grant_o, t_cyc_o});
    end
  endtask

  task automatic test_alternation();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hA0;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hB0;
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL alt_idle got=%b exp=00", grant_o);
    end
    tick();
    t_ack_i = 1;
    @(negedge clk);
    vectors++;
    if ({grant_o, t_adr_o, m0_ack_o, m1_ack_o} !== {2'b01, 32'hA0, 2'b10}) begin
      miscompares++;
      $display("FAIL alt_first got g=%b adr=%h ack=%b%b exp g=01 adr=a0 ack=10",
               grant_o, t_adr_o, m0_ack_o, m1_ack_o);
    end
    tick();
    t_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    @(negedge clk);
    vectors++;
    if ({grant_o, t_cyc_o, m1_ack_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL alt_dead got=%b exp=0000", {grant_o, t_cyc_o, m1_ack_o});
    end
    tick();
    t_ack_i = 1;
    @(negedge clk);
    vectors++;
    if ({grant_o, t_adr_o, m0_ack_o, m1_ack_o} !== {2'b10, 32'hB0, 2'b01}) begin
      miscompares++;
      $display("FAIL alt_second got g=%b adr=%h ack=%b%b exp g=10 adr=b0 ack=01",
               grant_o, t_adr_o, m0_ack_o, m1_ack_o);
    end
    tick();
    idle_inputs();
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL alt_third got=%b exp=01", grant_o);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_locked_reads();
    idle_inputs();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h300;
    for (int i = 1; i <= 4; i++) begin
      t_ack_i = 1; t_dat_i = 32'(i); m1_adr_i = 32'h200 + 32'(4 * i);
      @(negedge clk);
      vectors++;
      if ({grant_o, m1_ack_o, m1_dat_o, m0_ack_o, m0_err_o, m0_dat_o} !==
          {2'b10, 1'b1, 32'(i), 2'b00, 32'h0}) begin
        miscompares++;
        $display("FAIL lock_read%0d got g=%b m1=%b/%h m0=%b%b/%h exp g=10 m1=1/%h m0=00/0",
                 i, grant_o, m1_ack_o, m1_dat_o, m0_ack_o, m0_err_o, m0_dat_o, 32'(i));
      end
      tick();
    end
    m1_cyc_i = 0; m1_stb_i = 0; t_ack_i = 1; t_dat_i = '0;
    tick();
    @(negedge clk);
    vectors++;
    if ({grant_o, m0_ack_o, m0_dat_o} !== 35'b0) begin
      miscompares++;
      $display("FAIL lock_dead got g=%b ack=%b dat=%h exp 00/0/0", grant_o, m0_ack_o, m0_dat_o);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({grant_o, t_adr_o, m0_ack_o} !== {2'b01, 32'h300, 1'b1}) begin
      miscompares++;
      $display("FAIL lock_handover got g=%b adr=%h ack=%b exp 01/300/1", grant_o, t_adr_o, m0_ack_o);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    idle_inputs();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h400;
    tick();
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      vectors++;
      if ({t_cyc_o, m0_err_o, timeout_o, m1_err_o, m0_ack_o} !== {1'b1, (k == TO) ? 2'b11 : 2'b00, 2'b00}) begin
        miscompares++;
        $display("FAIL to_stb%0d got cyc/err/to/m1err/ack=%b exp=%b", k,
                 {t_cyc_o, m0_err_o, timeout_o, m1_err_o, m0_ack_o}, {1'b1, (k == TO) ? 2'b11 : 2'b00, 2'b00});
      end
      tick();
    end
    m1_cyc_i = 1; m1_stb_i = 1; t_ack_i = 1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vectors++;
      if ({t_cyc_o, t_stb_o, grant_o, timeout_o, m0_err_o, m1_ack_o, m0_ack_o} !== 8'b0) begin
        miscompares++;
        $display("FAIL to_flush%0d got=%b exp=0", j,
                 {t_cyc_o, t_stb_o, grant_o, timeout_o, m0_err_o, m1_ack_o, m0_ack_o});
      end
      tick();
    end
    m0_cyc_i = 0; m0_stb_i = 0; t_ack_i = 0;
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b10) begin
      miscompares++;
      $display("FAIL to_exit got=%b exp=10", grant_o);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_ack_at_timeout();
    idle_inputs();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    for (int k = 1; k < TO; k++) tick();
    t_ack_i = 1;
    @(negedge clk);
    vectors++;
    if ({m0_ack_o, m0_err_o, timeout_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL ack_wins got ack/err/to=%b exp=100", {m0_ack_o, m0_err_o, timeout_o});
    end
    tick();
    t_ack_i = 0;
    @(negedge clk);
    vectors++;
    if ({m0_err_o, timeout_o, t_cyc_o, grant_o} !== 5'b00101) begin
      miscompares++;
      $display("FAIL ack_cleared got=%b exp=00101", {m0_err_o, timeout_o, t_cyc_o, grant_o});
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b10) begin
      miscompares++;
      $display("FAIL rstmid_pre got=%b exp=10", grant_o);
    end
    rst = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if ({grant_o, t_cyc_o, m1_ack_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstmid_drop got=%b exp=0000", {grant_o, t_cyc_o, m1_ack_o});
    end
    rst = 1'b0;
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    @(negedge clk);
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL rstmid_after got=%b exp=01", grant_o);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    int own;
    int last_m;
    int cnt;
    logic [141:0] got, exp;
    logic e_stb, e_fire, c0, c1;
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    own = -1; last_m = 1; cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(0, 5) != 0); else m0_cyc_i = ($urandom_range(0, 3) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(0, 5) != 0); else m1_cyc_i = ($urandom_range(0, 3) == 0);
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 3) != 0);
      m0_we_i = 1'($urandom); m0_sel_i = 4'($urandom); m0_adr_i = $urandom; m0_dat_i = $urandom;
      m1_we_i = 1'($urandom); m1_sel_i = 4'($urandom); m1_adr_i = $urandom; m1_dat_i = $urandom;
      t_ack_i = ($urandom_range(0, 4) == 0);
      t_dat_i = $urandom;
      @(negedge clk);
      c0 = m0_cyc_i; c1 = m1_cyc_i;
      e_stb  = (own == 0) ? m0_stb_i : (own == 1) ? m1_stb_i : 1'b0;
      e_fire = (own == 0 || own == 1) && e_stb && !t_ack_i && (cnt + 1 == TO);
      exp = '0;
      if (own == 0)
        exp = {2'b01, e_fire, m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
               t_ack_i, e_fire, t_dat_i, 2'b00, 32'h0};
      else if (own == 1)
        exp = {2'b10, e_fire, m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
               2'b00, 32'h0, t_ack_i, e_fire, t_dat_i};
      got = {grant_o, timeout_o, t_cyc_o, t_stb_o, t_we_o, t_sel_o, t_adr_o, t_dat_o,
             m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rand%0d got=%h exp=%h", i, got, exp);
      end
      if (rst) begin
        own = -1; last_m = 1; cnt = 0;
      end else if (own == -1) begin
        if ((c0 && m0_stb_i) && (c1 && m1_stb_i)) own = (last_m == 0) ? 1 : 0;
        else if (c0 && m0_stb_i) own = 0;
        else if (c1 && m1_stb_i) own = 1;
        if (own != -1) begin
          last_m = own; cnt = 0;
        end
      end else if (own == 2) begin
        cnt = 0;
        if (!((last_m == 0) ? c0 : c1)) own = -1;
      end else begin
        cnt = (!e_stb || t_ack_i) ? 0 : cnt + 1;
        if (e_fire) begin
          own = 2; cnt = 0;
        end else if (!((own == 0) ? c0 : c1)) begin
          own = -1;
        end
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_alternation();
    test_locked_reads();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
